// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared defaults and width helpers for the RAM-backed FIFO controller.
package ram_ctrl_pkg;

  localparam int DATA_W_DEF   = 4;
  localparam int ADDR_W_DEF   = 8;
  localparam int DEPTH_DEF    = 8;
  localparam int AF_LEVEL_DEF = 6;

  // Occupancy needs to represent 0..depth inclusive, hence depth+1 states.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_w(DEPTH_DEF);

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Producer/consumer handshake plus the RAM-side port bundle of the FIFO controller.
interface ram_fifo_ctrl_if import ram_ctrl_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic              clr_err;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;
  logic              ram_write_en;
  logic [ADDR_W-1:0] ram_write_addr;
  logic [DATA_W-1:0] ram_write_data;
  logic              ram_read_en;
  logic [ADDR_W-1:0] ram_read_addr;
  logic [DATA_W-1:0] ram_read_data;

  // Environment side: producer, consumer and the RAM's read data.
  modport master (
    output push, push_data, pop, clr_err, ram_read_data,
    input  pop_data, pop_valid, full, empty, almost_full, count,
           overflow, underflow, ram_write_en, ram_write_addr,
           ram_write_data, ram_read_en, ram_read_addr
  );

  // Controller side.
  modport slave (
    input  push, push_data, pop, clr_err, ram_read_data,
    output pop_data, pop_valid, full, empty, almost_full, count,
           overflow, underflow, ram_write_en, ram_write_addr,
           ram_write_data, ram_read_en, ram_read_addr
  );

endinterface

// File: rtl/ram_fifo_ctrl_ptr.sv
// Wrapping FIFO pointer: counts 0..DEPTH-1 and returns to 0, so DEPTH
// need not be a power of two.
module ram_fifo_ptr #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     advance,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int PTR_W = $clog2(DEPTH);

  // Step the pointer on each accepted transfer, wrapping at the last entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO sequencer for an external single-write / single-read RAM with a
// registered one-cycle read. Holds pointers, occupancy and flags only.
module ram_fifo_ctrl import ram_ctrl_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AF_LEVEL = AF_LEVEL_DEF
) (
  input  logic          clk,
  input  logic          rst,
  ram_fifo_ctrl_if.slave bus
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic              full_w;
  logic              empty_w;
  logic              push_acc;
  logic              pop_acc;
  logic              pop_valid_q;
  logic              overflow_q;
  logic              underflow_q;

  // Flags come from the registered count; accepts never look through a
  // same-cycle transfer, which also keeps the RAM addresses from colliding.
  assign full_w   = (count_q == CNT_W'(DEPTH));
  assign empty_w  = (count_q == '0);
  assign push_acc = bus.push & ~full_w & ~rst;
  assign pop_acc  = bus.pop & ~empty_w & ~rst;

  ram_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (push_acc),
    .ptr     (wr_ptr)
  );

  ram_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (pop_acc),
    .ptr     (rd_ptr)
  );

  // Occupancy moves only when exactly one side transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (push_acc && !pop_acc) begin
      count_q <= count_q + CNT_W'(1);
    end else if (pop_acc && !push_acc) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  // Read data returns one cycle after the accepted pop, matching the RAM's
  // registered output; sticky errors let a new error win over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pop_valid_q <= pop_acc;
      if (bus.push && full_w) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_err) begin
        overflow_q <= 1'b0;
      end
      if (bus.pop && empty_w) begin
        underflow_q <= 1'b1;
      end else if (bus.clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign rd_data = bus.ram_read_data;

  assign bus.ram_write_en   = push_acc;
  assign bus.ram_write_addr = ADDR_W'(wr_ptr);
  assign bus.ram_write_data = bus.push_data;
  assign bus.ram_read_en    = pop_acc;
  assign bus.ram_read_addr  = ADDR_W'(rd_ptr);

  assign bus.pop_data    = rd_data;
  assign bus.pop_valid   = pop_valid_q;
  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.almost_full = (count_q >= CNT_W'(AF_LEVEL));
  assign bus.count       = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl with a behavioural RAM beside it and
// a scoreboard queue of accepted push data.
module tb_ram_fifo_ctrl;
  import ram_ctrl_pkg::*;

  localparam int DW    = 4;
  localparam int AW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int CW    = cnt_w(DEPTH);

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] sb[$];
  logic [DW-1:0] m_pop_exp;
  int            m_count;
  logic          m_pv;

  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) bus ();

  ram_fifo_ctrl #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Behavioural RAM: write port plus registered one-cycle read port.
  always @(posedge clk) begin
    if (bus.ram_write_en) mem[bus.ram_write_addr] <= bus.ram_write_data;
    if (bus.ram_read_en) bus.ram_read_data <= mem[bus.ram_read_addr];
  end

  task automatic set_in(input logic p, input logic [DW-1:0] d, input logic q, input logic c);
    bus.push      = p;
    bus.push_data = d;
    bus.pop       = q;
    bus.clr_err   = c;
  endtask

  // Updates the reference model for the coming edge, then waits to the next negedge.
  task automatic advance();
    logic pacc;
    logic qacc;
    pacc = bus.push && (m_count != DEPTH) && !rst;
    qacc = bus.pop && (m_count != 0) && !rst;
    if (rst) begin
      m_count = 0;
      m_pv    = 1'b0;
      sb.delete();
    end else begin
      if (qacc) m_pop_exp = sb.pop_front();
      if (pacc) sb.push_back(bus.push_data);
      m_count = m_count + int'(pacc) - int'(qacc);
      m_pv    = qacc;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b1, 4'h5, 1'b1, 1'b0);
    advance();
    #1;
    n_checks++;
    if (bus.ram_write_en !== 1'b0 || bus.ram_read_en !== 1'b0)
      $display("[TB] FAIL reset_enables: got we=%b re=%b expected 0/0", bus.ram_write_en, bus.ram_read_en);
    else n_pass++;
    advance();
    n_checks++;
    if (bus.count !== CW'(0) || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.almost_full !== 1'b0)
      $display("[TB] FAIL reset_state: got count=%0d empty=%b full=%b af=%b expected 0/1/0/0",
               bus.count, bus.empty, bus.full, bus.almost_full);
    else n_pass++;
    n_checks++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.pop_valid !== 1'b0)
      $display("[TB] FAIL reset_flags: got ovf=%b unf=%b pv=%b expected 0/0/0",
               bus.overflow, bus.underflow, bus.pop_valid);
    else n_pass++;
    rst = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0);
    advance();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, DW'(i + 1), 1'b0, 1'b0);
      #1;
      n_checks++;
      if (bus.ram_write_en !== 1'b1 || bus.ram_write_addr !== AW'(i))
        $display("[TB] FAIL fill_write: got we=%b addr=%0d expected 1/%0d", bus.ram_write_en, bus.ram_write_addr, i);
      else n_pass++;
      advance();
      n_checks++;
      if (bus.count !== CW'(i + 1) || bus.almost_full !== (i + 1 >= AF) || bus.full !== (i == DEPTH - 1))
        $display("[TB] FAIL fill_flags: got count=%0d af=%b full=%b expected %0d/%b/%b",
                 bus.count, bus.almost_full, bus.full, i + 1, (i + 1 >= AF), (i == DEPTH - 1));
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    set_in(1'b1, 4'hF, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.ram_write_en !== 1'b0)
      $display("[TB] FAIL ovf_write_blocked: got we=%b expected 0", bus.ram_write_en);
    else n_pass++;
    advance();
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.count !== CW'(DEPTH))
      $display("[TB] FAIL ovf_set: got ovf=%b count=%0d expected 1/%0d", bus.overflow, bus.count, DEPTH);
    else n_pass++;
    set_in(1'b0, '0, 1'b0, 1'b0);
    advance();
    n_checks++;
    if (bus.overflow !== 1'b1)
      $display("[TB] FAIL ovf_sticky: got ovf=%b expected 1", bus.overflow);
    else n_pass++;
    set_in(1'b0, '0, 1'b0, 1'b1);
    advance();
    n_checks++;
    if (bus.overflow !== 1'b0)
      $display("[TB] FAIL ovf_clear: got ovf=%b expected 0", bus.overflow);
    else n_pass++;
    set_in(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b0, '0, 1'b1, 1'b0);
      #1;
      n_checks++;
      if (bus.ram_read_en !== 1'b1 || bus.ram_read_addr !== AW'(i))
        $display("[TB] FAIL drain_read: got re=%b addr=%0d expected 1/%0d", bus.ram_read_en, bus.ram_read_addr, i);
      else n_pass++;
      advance();
      n_checks++;
      if (bus.pop_valid !== 1'b1 || bus.pop_data !== DW'(i + 1))
        $display("[TB] FAIL drain_data: got pv=%b data=%h expected 1/%h", bus.pop_valid, bus.pop_data, DW'(i + 1));
      else n_pass++;
    end
    n_checks++;
    if (bus.empty !== 1'b1 || bus.count !== CW'(0))
      $display("[TB] FAIL drain_empty: got empty=%b count=%0d expected 1/0", bus.empty, bus.count);
    else n_pass++;
    set_in(1'b0, '0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.ram_read_en !== 1'b0)
      $display("[TB] FAIL unf_read_blocked: got re=%b expected 0", bus.ram_read_en);
    else n_pass++;
    advance();
    n_checks++;
    if (bus.underflow !== 1'b1 || bus.pop_valid !== 1'b0)
      $display("[TB] FAIL unf_set: got unf=%b pv=%b expected 1/0", bus.underflow, bus.pop_valid);
    else n_pass++;
    set_in(1'b0, '0, 1'b0, 1'b1);
    advance();
    n_checks++;
    if (bus.underflow !== 1'b0)
      $display("[TB] FAIL unf_clear: got unf=%b expected 0", bus.underflow);
    else n_pass++;
    set_in(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    for (int round = 0; round < 2; round++) begin
      int n;
      int start;
      n     = (round == 0) ? 5 : 6;
      start = (round == 0) ? 0 : 5;
      for (int i = 0; i < n; i++) begin
        set_in(1'b1, DW'(i * 3 + round + 2), 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.ram_write_en !== 1'b1 || bus.ram_write_addr !== AW'((start + i) % DEPTH))
          $display("[TB] FAIL wrap_waddr: got we=%b addr=%0d expected 1/%0d",
                   bus.ram_write_en, bus.ram_write_addr, (start + i) % DEPTH);
        else n_pass++;
        advance();
      end
      for (int i = 0; i < n; i++) begin
        set_in(1'b0, '0, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (bus.ram_read_addr !== AW'((start + i) % DEPTH))
          $display("[TB] FAIL wrap_raddr: got addr=%0d expected %0d", bus.ram_read_addr, (start + i) % DEPTH);
        else n_pass++;
        advance();
        n_checks++;
        if (bus.pop_valid !== 1'b1 || bus.pop_data !== m_pop_exp)
          $display("[TB] FAIL wrap_data: got pv=%b data=%h expected 1/%h", bus.pop_valid, bus.pop_data, m_pop_exp);
        else n_pass++;
      end
      set_in(1'b0, '0, 1'b0, 1'b0);
      advance();
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, DW'(i + 4), 1'b0, 1'b0);
      advance();
    end
    set_in(1'b1, 4'hC, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.ram_write_en !== 1'b1 || bus.ram_read_en !== 1'b1)
      $display("[TB] FAIL simul3_enables: got we=%b re=%b expected 1/1", bus.ram_write_en, bus.ram_read_en);
    else n_pass++;
    advance();
    n_checks++;
    if (bus.count !== CW'(3) || bus.pop_valid !== 1'b1 || bus.pop_data !== m_pop_exp)
      $display("[TB] FAIL simul3_result: got count=%0d pv=%b data=%h expected 3/1/%h",
               bus.count, bus.pop_valid, bus.pop_data, m_pop_exp);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, '0, 1'b1, 1'b0);
      advance();
      n_checks++;
      if (bus.pop_valid !== 1'b1 || bus.pop_data !== m_pop_exp)
        $display("[TB] FAIL simul_drain: got pv=%b data=%h expected 1/%h", bus.pop_valid, bus.pop_data, m_pop_exp);
      else n_pass++;
    end
    set_in(1'b1, 4'h9, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.ram_write_en !== 1'b1 || bus.ram_read_en !== 1'b0)
      $display("[TB] FAIL simul0_enables: got we=%b re=%b expected 1/0", bus.ram_write_en, bus.ram_read_en);
    else n_pass++;
    advance();
    n_checks++;
    if (bus.count !== CW'(1) || bus.underflow !== 1'b1 || bus.pop_valid !== 1'b0)
      $display("[TB] FAIL simul0_result: got count=%0d unf=%b pv=%b expected 1/1/0",
               bus.count, bus.underflow, bus.pop_valid);
    else n_pass++;
    set_in(1'b0, '0, 1'b0, 1'b1);
    advance();
    set_in(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, DW'(i + 13), 1'b0, 1'b0);
      advance();
    end
    n_checks++;
    if (bus.count !== CW'(4))
      $display("[TB] FAIL rmid_count4: got count=%0d expected 4", bus.count);
    else n_pass++;
    set_in(1'b0, '0, 1'b1, 1'b0);
    advance();
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.pop_valid !== 1'b1 || bus.pop_data !== m_pop_exp || bus.ram_read_en !== 1'b0)
      $display("[TB] FAIL rmid_inflight: got pv=%b data=%h re=%b expected 1/%h/0",
               bus.pop_valid, bus.pop_data, bus.ram_read_en, m_pop_exp);
    else n_pass++;
    advance();
    n_checks++;
    if (bus.count !== CW'(0) || bus.empty !== 1'b1 || bus.pop_valid !== 1'b0)
      $display("[TB] FAIL rmid_after: got count=%0d empty=%b pv=%b expected 0/1/0",
               bus.count, bus.empty, bus.pop_valid);
    else n_pass++;
    rst = 1'b0;
    set_in(1'b1, 4'hA, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.ram_write_en !== 1'b1 || bus.ram_write_addr !== AW'(0))
      $display("[TB] FAIL rmid_waddr: got we=%b addr=%0d expected 1/0", bus.ram_write_en, bus.ram_write_addr);
    else n_pass++;
    advance();
    set_in(1'b0, '0, 1'b1, 1'b0);
    advance();
    n_checks++;
    if (bus.pop_valid !== 1'b1 || bus.pop_data !== 4'hA || bus.empty !== 1'b1)
      $display("[TB] FAIL rmid_readback: got pv=%b data=%h empty=%b expected 1/a/1",
               bus.pop_valid, bus.pop_data, bus.empty);
    else n_pass++;
    set_in(1'b0, '0, 1'b0, 1'b0);
    advance();
  endtask

  // Sequence the scenarios, then report.
  initial begin
    m_count   = 0;
    m_pv      = 1'b0;
    m_pop_exp = '0;
    test_reset();
    test_fill();
    test_overflow();
    test_back_to_back();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
